// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

  // Byte size of one instruction; sequential fetch and link addresses step by this.
  localparam int INSN_BYTES = 4;

  // Which rule produced the next fetch address.
  typedef enum logic [2:0] {
    PCSRC_SEQ,
    PCSRC_COND,
    PCSRC_UNCOND,
    PCSRC_REG,
    PCSRC_RET
  } pc_src_t;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// a simultaneous push and pop replaces the top entry in place.
module return_stack #(
  parameter int ADDR_WIDTH = 64,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  valid,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]      ptr;      // next slot to write
  logic [PTR_W-1:0]      top_idx;  // most recently written slot
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  replace;

  assign top_idx = ptr - PTR_W'(1);
  assign full    = (count == CNT_W'(RAS_DEPTH));
  assign valid   = (count != '0);
  assign top     = mem[top_idx];
  assign replace = push && pop && valid;

  // Entry storage: write the new link address at the top or the next free slot.
  // NOTE: entry contents carry no reset; count gates every read, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      if (replace) mem[top_idx] <= push_data;
      else         mem[ptr]     <= push_data;
    end
  end

  // Pointer, occupancy and sticky overflow tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (replace) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (full) overflow <= 1'b1;
      else      count    <= count + CNT_W'(1);
    end else if (pop && valid) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with prioritised next-PC selection and a
// return-address stack used purely as a return-target checker.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    RAS_DEPTH  = 4,
  parameter int                    IMM_SHIFT  = 2
) (
  input  logic                  CLK,
  input  logic                  resetl,
  input  logic                  Stall,
  input  logic                  Branch,
  input  logic                  ALUZero,
  input  logic                  Uncondbranch,
  input  logic                  RegBranch,
  input  logic                  Ret,
  input  logic                  Link,
  input  logic [ADDR_WIDTH-1:0] SignExtImm,
  input  logic [ADDR_WIDTH-1:0] RegTarget,
  output logic [ADDR_WIDTH-1:0] CurrentPC,
  output logic [ADDR_WIDTH-1:0] NextPC,
  output logic                  RASValid,
  output logic                  RASMispredict,
  output logic                  RASOverflow
);

  pc_src_t               pc_src;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] rel_pc;
  logic [ADDR_WIDTH-1:0] ras_top;

  // Both adders wrap silently; the shift drops bits beyond ADDR_WIDTH.
  assign seq_pc = CurrentPC + ADDR_WIDTH'(INSN_BYTES);
  assign rel_pc = CurrentPC + (SignExtImm << IMM_SHIFT);

  // Resolve the branch source in fixed priority order.
  // NOTE: default assigned first so every path drives pc_src and no latch is inferred.
  always_comb begin
    pc_src = PCSRC_SEQ;
    if (Ret)                      pc_src = PCSRC_RET;
    else if (RegBranch)           pc_src = PCSRC_REG;
    else if (Uncondbranch)        pc_src = PCSRC_UNCOND;
    else if (Branch && ALUZero)   pc_src = PCSRC_COND;
  end

  // Map the selected source to the next fetch address.
  always_comb begin
    NextPC = seq_pc;
    case (pc_src)
      PCSRC_RET, PCSRC_REG:     NextPC = RegTarget;
      PCSRC_UNCOND, PCSRC_COND: NextPC = rel_pc;
      default:                  NextPC = seq_pc;
    endcase
  end

  // PC register; holds while stalled.
  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl)     CurrentPC <= RESET_PC;
    else if (!Stall) CurrentPC <= NextPC;
  end

  return_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst_n     (resetl),
    .push      (Link && !Stall),
    .pop       (Ret && !Stall),
    .push_data (seq_pc),
    .top       (ras_top),
    .valid     (RASValid),
    .overflow  (RASOverflow)
  );

  // The architectural return target is always RegTarget; the stack only flags disagreement.
  assign RASMispredict = Ret && RASValid && (ras_top != RegTarget);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_pc_sequencer;

  localparam int          AW   = 64;
  localparam logic [63:0] RPC  = 64'h1000;
  localparam int          DEPTH = 4;

  logic          CLK = 1'b0;
  logic          resetl = 1'b0;
  logic          Stall = 1'b0, Branch = 1'b0, ALUZero = 1'b0, Uncondbranch = 1'b0;
  logic          RegBranch = 1'b0, Ret = 1'b0, Link = 1'b0;
  logic [AW-1:0] SignExtImm = '0, RegTarget = '0;
  logic [AW-1:0] CurrentPC, NextPC;
  logic          RASValid, RASMispredict, RASOverflow;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (RPC),
    .RAS_DEPTH  (DEPTH),
    .IMM_SHIFT  (2)
  ) dut (
    .CLK           (CLK),
    .resetl        (resetl),
    .Stall         (Stall),
    .Branch        (Branch),
    .ALUZero       (ALUZero),
    .Uncondbranch  (Uncondbranch),
    .RegBranch     (RegBranch),
    .Ret           (Ret),
    .Link          (Link),
    .SignExtImm    (SignExtImm),
    .RegTarget     (RegTarget),
    .CurrentPC     (CurrentPC),
    .NextPC        (NextPC),
    .RASValid      (RASValid),
    .RASMispredict (RASMispredict),
    .RASOverflow   (RASOverflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_pc;
  logic [63:0] m_ras[$];   // back = most recent return address
  logic        m_ovf;

  function automatic logic [63:0] model_next();
    if (Ret || RegBranch)                  return RegTarget;
    if (Uncondbranch || (Branch && ALUZero)) return m_pc + (SignExtImm << 2);
    return m_pc + 64'd4;
  endfunction

  function automatic logic model_mispredict();
    return Ret && (m_ras.size() > 0) && (m_ras[m_ras.size()-1] != RegTarget);
  endfunction

  task automatic model_reset();
    m_pc  = RPC;
    m_ras.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic [63:0] np;
    logic [63:0] ret_addr;
    np       = model_next();
    ret_addr = m_pc + 64'd4;
    if (Ret && Link && m_ras.size() > 0) begin
      m_ras[m_ras.size()-1] = ret_addr;
    end else begin
      if (Ret && m_ras.size() > 0) void'(m_ras.pop_back());
      if (Link) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(ret_addr);
      end
    end
    m_pc = np;
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge CLK or negedge resetl);
      if (!resetl)     model_reset();
      else if (!Stall) model_step();
    end
  end

  // Compare every cycle mid-period, once inputs and outputs have settled.
  always @(negedge CLK) begin
    if (resetl) begin
      check("cmp_current_pc", CurrentPC, m_pc);
      check("cmp_next_pc", NextPC, model_next());
      check("cmp_ras_valid", 64'(RASValid), 64'(m_ras.size() > 0));
      check("cmp_ras_mispredict", 64'(RASMispredict), 64'(model_mispredict()));
      check("cmp_ras_overflow", 64'(RASOverflow), 64'(m_ovf));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pc(input logic [63:0] a);
    RegBranch = 1'b1;
    RegTarget = a;
    tick();
    RegBranch = 1'b0;
  endtask

  initial begin : stim
    logic [63:0] ret_exp [4];
    ret_exp = '{64'h3018, 64'h3014, 64'h3010, 64'h300C};

    // Reset and idle sequential fetch.
    #12 resetl = 1'b1;
    check("reset_pc", CurrentPC, 64'h1000);
    check("reset_ras_valid", 64'(RASValid), 64'd0);
    check("reset_overflow", 64'(RASOverflow), 64'd0);
    tick(); check("idle_pc1", CurrentPC, 64'h1004);
    tick(); check("idle_pc2", CurrentPC, 64'h1008);
    tick(); check("idle_pc3", CurrentPC, 64'h100C);

    // Conditional branch taken / not taken.
    set_pc(64'h2000);
    Branch = 1'b1; ALUZero = 1'b1; SignExtImm = 64'hFFFF_FFFF_FFFF_FFFC;
    #1 check("cond_taken_next", NextPC, 64'h1FF0);
    ALUZero = 1'b0;
    #1 check("cond_not_taken_next", NextPC, 64'h2004);
    ALUZero = 1'b1;
    tick(); check("cond_taken_pc", CurrentPC, 64'h1FF0);
    Branch = 1'b0; ALUZero = 1'b0;

    // Branch-and-link, then matching return.
    set_pc(64'h3000);
    Uncondbranch = 1'b1; Link = 1'b1; SignExtImm = 64'h10;
    tick();
    Uncondbranch = 1'b0; Link = 1'b0;
    check("bl_pc", CurrentPC, 64'h3040);
    check("bl_ras_valid", 64'(RASValid), 64'd1);
    Ret = 1'b1; RegTarget = 64'h3005;
    #1 check("ret_wrong_target", 64'(RASMispredict), 64'd1);
    RegTarget = 64'h3004;
    #1 check("ret_right_target", 64'(RASMispredict), 64'd0);
    check("ret_next", NextPC, 64'h3004);
    tick(); Ret = 1'b0;
    check("ret_pc", CurrentPC, 64'h3004);
    check("ret_ras_empty", 64'(RASValid), 64'd0);

    // Five pushes into a four-entry stack, then LIFO returns.
    Link = 1'b1;
    repeat (5) tick();
    Link = 1'b0;
    check("ovf_set", 64'(RASOverflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      Ret = 1'b1; RegTarget = ret_exp[i];
      #1 check("lifo_ret", 64'(RASMispredict), 64'd0);
      tick();
    end
    check("lifo_drained", 64'(RASValid), 64'd0);
    RegTarget = 64'h4000;
    #1 check("ret_empty_no_mispredict", 64'(RASMispredict), 64'd0);
    tick(); Ret = 1'b0;
    check("ret_empty_valid", 64'(RASValid), 64'd0);
    check("ovf_sticky", 64'(RASOverflow), 64'd1);

    // Ret together with Link replaces the top entry.
    Link = 1'b1;
    tick();                                   // push 0x4004, PC 0x4004
    Ret = 1'b1; RegTarget = 64'h4100;
    #1 check("replace_mispredict", 64'(RASMispredict), 64'd1);
    tick();                                   // top becomes 0x4008
    Link = 1'b0; RegTarget = 64'h4008;
    #1 check("replace_top", 64'(RASMispredict), 64'd0);
    check("replace_count", 64'(RASValid), 64'd1);
    tick(); Ret = 1'b0;
    check("replace_popped", 64'(RASValid), 64'd0);

    // Stall holds PC and stack while NextPC tracks the branch.
    set_pc(64'h5000);
    Stall = 1'b1; Uncondbranch = 1'b1; SignExtImm = 64'h8; Link = 1'b1;
    #1 check("stall_next", NextPC, 64'h5020);
    tick(); check("stall_pc1", CurrentPC, 64'h5000);
    tick(); check("stall_pc2", CurrentPC, 64'h5000);
    check("stall_ras_held", 64'(RASValid), 64'd0);
    check("stall_next_hold", NextPC, 64'h5020);
    Stall = 1'b0; Link = 1'b0;
    tick(); check("unstall_pc", CurrentPC, 64'h5020);
    Uncondbranch = 1'b0;

    // Wrap-around at the top of the address space.
    set_pc(64'hFFFF_FFFF_FFFF_FFFC);
    #1 check("wrap_next", NextPC, 64'h0);
    tick(); check("wrap_pc", CurrentPC, 64'h0);

    // Asynchronous reset mid-cycle.
    tick();
    #3 resetl = 1'b0;
    #1 check("async_reset_pc", CurrentPC, 64'h1000);
    check("async_reset_valid", 64'(RASValid), 64'd0);
    check("async_reset_ovf", 64'(RASOverflow), 64'd0);
    #2 resetl = 1'b1;
    tick(); check("post_reset_pc", CurrentPC, 64'h1004);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit that owns the fetch address and computes the next one each cycle. It supports sequential, conditional, unconditional, register-indirect and return branches, plus stall, with parametrised address width. A small return-address stack (RAS) is pushed on linking branches and checked on returns. It sits between the control/ALU outputs and instruction memory, replacing the purely combinational next-PC adder of earlier designs.

## Interface
- ADDR_WIDTH, 64, width of PC, immediates and targets
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)
- IMM_SHIFT, 2, left shift applied to SignExtImm (instruction size log2)
- CLK  in  1  clock; all state updates on rising edge
- resetl  in  1  asynchronous, active-low reset
- Stall  in  1  hold PC and RAS this cycle
- Branch  in  1  conditional branch (taken when ALUZero)
- ALUZero  in  1  ALU zero flag
- Uncondbranch  in  1  PC-relative unconditional branch
- RegBranch  in  1  register-indirect branch to RegTarget
- Ret  in  1  return: pop RAS, branch to RegTarget
- Link  in  1  push CurrentPC+4 onto RAS (BL/BLR)
- SignExtImm  in  ADDR_WIDTH  sign-extended word offset
- RegTarget  in  ADDR_WIDTH  register-file target address
- CurrentPC  out  ADDR_WIDTH  registered PC
- NextPC  out  ADDR_WIDTH  combinational next PC
- RASValid  out  1  RAS non-empty
- RASMispredict  out  1  combinational: Ret with RAS non-empty and top ≠ RegTarget
- RASOverflow  out  1  sticky: push occurred while full

## Operation
- Source priority: Ret > RegBranch > Uncondbranch > (Branch && ALUZero) > sequential.
- Ret / RegBranch: NextPC = RegTarget. RAS is a checker only; architectural target is always RegTarget.
- Uncond / taken cond: NextPC = CurrentPC + (SignExtImm << IMM_SHIFT).
- Sequential: NextPC = CurrentPC + 4.
- All arithmetic is modulo 2^ADDR_WIDTH. Shifted-out bits are discarded, and wrap-around is silent.
- Link pushes CurrentPC+4 regardless of the selected branch source.
- Ret pops when RASValid. Ret when empty: no pop, RASMispredict=0.
- Ret and Link in the same cycle: replace top with CurrentPC+4, count unchanged. If empty, this is a plain push.
- Push when full: circular overwrite of the oldest entry, count stays RAS_DEPTH, RASOverflow set until reset.
- Stall=1: CurrentPC, RAS contents, pointer and count hold. NextPC and RASMispredict still reflect inputs.

## Timing
- Reset (async assert, sync-safe deassert): CurrentPC=RESET_PC, RAS count=0, pointer=0, RASValid=0, RASOverflow=0. RAS entry contents are don't-care.
- NextPC has zero latency (combinational). CurrentPC takes NextPC at the next rising edge when Stall=0.
- RAS push/pop take effect at the same edge, and RASValid updates from the post-edge count.
- Reset mid-operation discards RAS state. The first post-reset cycle fetches RESET_PC.
- Control inputs are sampled only at rising edges. No handshake.

## Structure
- Shared package pc_pkg:
  - pc_src_t enum: PCSRC_SEQ, PCSRC_COND, PCSRC_UNCOND, PCSRC_REG, PCSRC_RET
  - INSN_BYTES=4
- Sub-module return_stack, parameterised by ADDR_WIDTH and RAS_DEPTH:
  - contains the circular buffer, top pointer and count
  - ports: push, pop, push_data, top, valid, overflow
- Top level holds the PC register, source select and adders.

## Test plan
- Reset with RESET_PC=0x1000, then 3 idle cycles -> CurrentPC 0x1000, 0x1004, 0x1008, 0x100C.
- At PC=0x2000, Branch=1, ALUZero=1, SignExtImm=-4 -> next PC 0x1FF0. Same stimulus with ALUZero=0 -> 0x2004.
- At PC=0x3000, Uncondbranch+Link with imm 0x10 -> PC 0x3040, RAS top 0x3004. Then Ret with RegTarget=0x3004 -> PC 0x3004, RASMispredict=0, RASValid=0.
- Five Link pushes with RAS_DEPTH=4 -> RASOverflow=1, oldest entry lost. Four Rets then return the last four addresses in LIFO order. A fifth Ret -> RASValid=0, no pop.
- Stall=1 with Uncondbranch=1 for 2 cycles -> CurrentPC unchanged and RAS unchanged. NextPC shows the branch target throughout.
- PC=2^ADDR_WIDTH−4, sequential step -> PC wraps to 0. Assert resetl=0 mid-cycle -> CurrentPC=RESET_PC immediately.
